// File: rtl/slave_spi_prog.sv
// ---------------------------------------------------------------------------
// slave_spi_prog
//
// Mode-0 SPI slave that lets an external host read and write the program
// (code) memory and the data memory of the core through one shared
// programming clock pulse.  All SPI pins are synchronised into CLK; every
// decision is taken on the synchronised copies.
//
// Frame (MSB first, FW = 4 + ADDR_W + W bits):
//   [FW-1] R/nW   [FW-2] space (1 = data)   [FW-3] burst   [FW-4] reserved
//   [FW-5 -: ADDR_W] address                [W-1:0] data
// The CS window after a command shifts the response frame out on MISO.
//
// Ports:
//   CLK       system clock (only clock of the block)
//   RST_N     synchronous active-low reset
//   CS        SPI chip select, active low, asynchronous
//   SCK       SPI clock, idle low, asynchronous
//   MOSI      SPI data in, sampled on SCK rise
//   MISO      SPI data out, updated after SCK fall
//   cin_prg   code memory read data      cout_prg  code memory write data
//   cadd_prg  code memory address        cwe_prg   code memory write enable
//   din_prg   data memory read data      dout_prg  data memory write data
//   dadd_prg  data memory address        dwe_prg   data memory write enable
//   prog_clk  programming clock pulse to both memories
//   busy      high whenever the FSM is outside IDLE_I / IDLE_O
//   err       one-cycle pulse when a frame or burst word is aborted
// ---------------------------------------------------------------------------
module slave_spi_prog #(
    parameter int ADDR_W  = 8,
    parameter int CDATA_W = 4,
    parameter int DDATA_W = 1
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               CS,
    input  logic               SCK,
    input  logic               MOSI,
    output logic               MISO,
    input  logic [CDATA_W-1:0] cin_prg,
    output logic [CDATA_W-1:0] cout_prg,
    output logic [ADDR_W-1:0]  cadd_prg,
    output logic               cwe_prg,
    input  logic [DDATA_W-1:0] din_prg,
    output logic [DDATA_W-1:0] dout_prg,
    output logic [ADDR_W-1:0]  dadd_prg,
    output logic               dwe_prg,
    output logic               prog_clk,
    output logic               busy,
    output logic               err
);

    localparam int W  = (CDATA_W > DDATA_W) ? CDATA_W : DDATA_W;
    localparam int FW = 4 + ADDR_W + W;
    localparam int CW = $clog2(FW + 1);

    typedef enum logic [3:0] {
        IDLE_I,
        SHIFT_I,
        DECODE,
        WR_SETUP,
        WR_CLK,
        WR_HOLD,
        SHIFT_B,
        RD_SETUP,
        RD_CLK,
        RD_CAP,
        WAIT_CS1,
        IDLE_O,
        SHIFT_O,
        WAIT_CS2
    } state_t;

    state_t state;
    state_t nstate;

    // Synchroniser stages.  CS is stored inverted ("selected") so that the
    // all-zero reset value means "not selected" and no phantom frame starts
    // right after reset while the host still holds CS high.
    logic cs_act_s1;
    logic cs_act_s2;
    logic sck_s1;
    logic sck_s2;
    logic sck_d;
    logic mosi_s1;
    logic mosi_s2;

    logic cs_act;
    logic sck_rise;
    logic sck_fall;

    logic [FW-1:0]     sh;
    logic [FW-1:0]     sh_nx;
    logic [CW-1:0]     cnt;
    logic [3:0]        hdr_r;
    logic [3:0]        hdr_nx;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] addr_nx;
    logic [W-1:0]      data_r;
    logic [W-1:0]      data_nx;
    logic [W-1:0]      rd_ext;
    logic [FW-1:0]     resp_r;
    logic [FW-1:0]     out_sh;
    logic              err_nx;
    logic              wr_nx;

    // Two-flop synchronisers plus the previous-SCK register used for edge
    // detection.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cs_act_s1 <= 1'b0;
            cs_act_s2 <= 1'b0;
            sck_s1    <= 1'b0;
            sck_s2    <= 1'b0;
            sck_d     <= 1'b0;
            mosi_s1   <= 1'b0;
            mosi_s2   <= 1'b0;
        end else begin
            cs_act_s1 <= ~CS;
            cs_act_s2 <= cs_act_s1;
            sck_s1    <= SCK;
            sck_s2    <= sck_s1;
            sck_d     <= sck_s2;
            mosi_s1   <= MOSI;
            mosi_s2   <= mosi_s1;
        end
    end

    assign cs_act   = cs_act_s2;
    assign sck_rise = sck_s2 & ~sck_d;
    assign sck_fall = ~sck_s2 & sck_d;

    // Next-state decode.  CS deassertion is checked before any SCK edge so
    // an abort always wins over a coincident shift.
    always_comb begin
        nstate = state;
        err_nx = 1'b0;
        case (state)
            IDLE_I: begin
                if (cs_act) nstate = SHIFT_I;
            end
            SHIFT_I: begin
                if (!cs_act) begin
                    nstate = IDLE_I;
                    err_nx = 1'b1;
                end else if (sck_rise && cnt == CW'(FW - 1)) begin
                    nstate = DECODE;
                end
            end
            DECODE: begin
                nstate = sh[FW-1] ? RD_SETUP : WR_SETUP;
            end
            WR_SETUP: nstate = WR_CLK;
            WR_CLK:   nstate = WR_HOLD;
            WR_HOLD: begin
                nstate = hdr_r[1] ? SHIFT_B : WAIT_CS1;
            end
            SHIFT_B: begin
                if (!cs_act) begin
                    nstate = IDLE_O;
                    err_nx = (cnt != '0);
                end else if (sck_rise && cnt == CW'(W - 1)) begin
                    nstate = WR_SETUP;
                end
            end
            RD_SETUP: nstate = RD_CLK;
            RD_CLK:   nstate = RD_CAP;
            RD_CAP:   nstate = WAIT_CS1;
            WAIT_CS1: begin
                if (!cs_act) nstate = IDLE_O;
            end
            IDLE_O: begin
                if (cs_act) nstate = SHIFT_O;
            end
            SHIFT_O: begin
                if (!cs_act) begin
                    nstate = IDLE_I;
                    err_nx = 1'b1;
                end else if (sck_rise && cnt == CW'(FW - 1)) begin
                    nstate = WAIT_CS2;
                end
            end
            WAIT_CS2: begin
                if (!cs_act) nstate = IDLE_I;
            end
            default: nstate = IDLE_I;
        endcase
    end

    // Next values of the command registers.  The full frame is unpacked in
    // DECODE; a completed burst word bumps the address (wrapping) and takes
    // the last W shifted bits as the new data.
    always_comb begin
        sh_nx   = {sh[FW-2:0], mosi_s2};
        hdr_nx  = hdr_r;
        addr_nx = addr_r;
        data_nx = data_r;
        if (state == DECODE) begin
            hdr_nx  = sh[FW-1 -: 4];
            addr_nx = sh[FW-5 -: ADDR_W];
            data_nx = sh[W-1:0];
        end else if (state == SHIFT_B && nstate == WR_SETUP) begin
            addr_nx = addr_r + ADDR_W'(1);
            data_nx = sh_nx[W-1:0];
        end
    end

    // Read data from the selected memory, zero-extended to the data field.
    always_comb begin
        rd_ext = '0;
        if (hdr_r[2]) begin
            rd_ext[DDATA_W-1:0] = din_prg;
        end else begin
            rd_ext[CDATA_W-1:0] = cin_prg;
        end
    end

    assign wr_nx = (nstate == WR_SETUP) || (nstate == WR_CLK) || (nstate == WR_HOLD);

    // State register.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= IDLE_I;
        end else begin
            state <= nstate;
        end
    end

    // Datapath and registered outputs.  Enables, prog_clk and busy are
    // decoded from the next state so they come straight out of flops.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sh       <= '0;
            cnt      <= '0;
            hdr_r    <= '0;
            addr_r   <= '0;
            data_r   <= '0;
            resp_r   <= '0;
            out_sh   <= '0;
            MISO     <= 1'b0;
            cout_prg <= '0;
            cadd_prg <= '0;
            cwe_prg  <= 1'b0;
            dout_prg <= '0;
            dadd_prg <= '0;
            dwe_prg  <= 1'b0;
            prog_clk <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            err      <= err_nx;
            busy     <= !((nstate == IDLE_I) || (nstate == IDLE_O));
            prog_clk <= (nstate == WR_CLK) || (nstate == RD_CLK);
            cwe_prg  <= wr_nx && !hdr_nx[2];
            dwe_prg  <= wr_nx && hdr_nx[2];
            hdr_r    <= hdr_nx;
            addr_r   <= addr_nx;
            data_r   <= data_nx;

            case (state)
                IDLE_I: begin
                    if (nstate == SHIFT_I) begin
                        sh  <= '0;
                        cnt <= '0;
                    end
                end
                SHIFT_I, SHIFT_B: begin
                    if (sck_rise) begin
                        sh  <= sh_nx;
                        cnt <= cnt + CW'(1);
                    end
                end
                WR_HOLD: begin
                    // Each completed write refreshes the echo, so a burst
                    // reports its final address and data.
                    resp_r <= {hdr_r, addr_r, data_r};
                    cnt    <= '0;
                end
                RD_CLK: begin
                    resp_r <= {hdr_r, addr_r, rd_ext};
                end
                IDLE_O: begin
                    if (nstate == SHIFT_O) begin
                        MISO   <= resp_r[FW-1];
                        out_sh <= {resp_r[FW-2:0], 1'b0};
                        cnt    <= '0;
                    end
                end
                SHIFT_O: begin
                    if (sck_rise) begin
                        cnt <= cnt + CW'(1);
                    end
                    if (sck_fall) begin
                        MISO   <= out_sh[FW-1];
                        out_sh <= {out_sh[FW-2:0], 1'b0};
                    end
                end
                default: ;
            endcase

            if (nstate == IDLE_I) begin
                MISO <= 1'b0;
            end

            // Memory address/data only move when an access starts, so they
            // hold their last value between operations and the previous
            // burst word stays on the bus until the next write begins.
            if (nstate == WR_SETUP || nstate == RD_SETUP) begin
                if (hdr_nx[2]) begin
                    dadd_prg <= addr_nx;
                    if (nstate == WR_SETUP) begin
                        dout_prg <= data_nx[DDATA_W-1:0];
                    end
                end else begin
                    cadd_prg <= addr_nx;
                    if (nstate == WR_SETUP) begin
                        cout_prg <= data_nx[CDATA_W-1:0];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_slave_spi_prog.sv
// ---------------------------------------------------------------------------
// tb_slave_spi_prog
//
// Self-checking bench for slave_spi_prog.  One instance at default
// parameters and one at ADDR_W=10, CDATA_W=8, DDATA_W=8 share SCK/MOSI and
// have separate chip selects.  Simple memory models sit behind both.
// ---------------------------------------------------------------------------
module tb_slave_spi_prog;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        CS = 1'b1;
    logic        CS2 = 1'b1;
    logic        SCK = 1'b0;
    logic        MOSI = 1'b0;

    logic        MISO;
    logic [3:0]  cin_prg, cout_prg;
    logic [7:0]  cadd_prg, dadd_prg;
    logic [0:0]  din_prg, dout_prg;
    logic        cwe_prg, dwe_prg, prog_clk, busy, err;

    logic        MISO_b;
    logic [7:0]  cin_b, cout_b, din_b, dout_b;
    logic [9:0]  cadd_b, dadd_b;
    logic        cwe_b, dwe_b, prog_clk_b, busy_b, err_b;

    logic [3:0]  cmem [256];
    logic [0:0]  dmem [256];
    logic [7:0]  cmem_b [1024];
    logic [7:0]  dmem_b [1024];

    int checks = 0;
    int errors = 0;

    int cwe_cyc = 0;
    int dwe_cyc = 0;
    int pclk_cyc = 0;
    int err_cyc = 0;
    logic [7:0] wa_q [$];
    logic [3:0] wd_q [$];

    typedef struct {
        logic [15:0] frame;
        logic [15:0] resp;
        int          n_cwe;
        int          n_dwe;
        int          n_pclk;
        logic [7:0]  addr;
        logic [3:0]  wdata;
    } vec_t;

    vec_t vecs [9];

    always #5 CLK = ~CLK;

    slave_spi_prog dut (
        .CLK(CLK), .RST_N(RST_N), .CS(CS), .SCK(SCK), .MOSI(MOSI), .MISO(MISO),
        .cin_prg(cin_prg), .cout_prg(cout_prg), .cadd_prg(cadd_prg), .cwe_prg(cwe_prg),
        .din_prg(din_prg), .dout_prg(dout_prg), .dadd_prg(dadd_prg), .dwe_prg(dwe_prg),
        .prog_clk(prog_clk), .busy(busy), .err(err)
    );

    slave_spi_prog #(.ADDR_W(10), .CDATA_W(8), .DDATA_W(8)) dut_b (
        .CLK(CLK), .RST_N(RST_N), .CS(CS2), .SCK(SCK), .MOSI(MOSI), .MISO(MISO_b),
        .cin_prg(cin_b), .cout_prg(cout_b), .cadd_prg(cadd_b), .cwe_prg(cwe_b),
        .din_prg(din_b), .dout_prg(dout_b), .dadd_prg(dadd_b), .dwe_prg(dwe_b),
        .prog_clk(prog_clk_b), .busy(busy_b), .err(err_b)
    );

    // Memory models: write on the CLK edge that ends the prog_clk cycle.
    assign cin_prg = cmem[cadd_prg];
    assign din_prg = dmem[dadd_prg];
    assign cin_b   = cmem_b[cadd_b];
    assign din_b   = dmem_b[dadd_b];

    always @(posedge CLK) begin
        if (cwe_prg && prog_clk) cmem[cadd_prg] <= cout_prg;
        if (dwe_prg && prog_clk) dmem[dadd_prg] <= dout_prg;
        if (cwe_b && prog_clk_b) cmem_b[cadd_b] <= cout_b;
        if (dwe_b && prog_clk_b) dmem_b[dadd_b] <= dout_b;
    end

    // Activity monitor for the default instance.
    always @(negedge CLK) begin
        if (cwe_prg) cwe_cyc++;
        if (dwe_prg) dwe_cyc++;
        if (prog_clk) pclk_cyc++;
        if (err) err_cyc++;
        if (cwe_prg && prog_clk) begin
            wa_q.push_back(cadd_prg);
            wd_q.push_back(cout_prg);
        end
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Compare one value and keep score.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic spiStart(input int sel);
        if (sel == 0) CS = 1'b0; else CS2 = 1'b0;
        repeat (6) @(negedge CLK);
    endtask

    task automatic spiEnd(input int sel);
        repeat (10) @(negedge CLK);
        if (sel == 0) CS = 1'b1; else CS2 = 1'b1;
        MOSI = 1'b0;
        repeat (6) @(negedge CLK);
    endtask

    // Shift n bits MSB first; MISO is sampled just before each SCK rise.
    task automatic spiBits(input int sel, input logic [31:0] tx, input int n, output logic [31:0] rx);
        rx = '0;
        for (int i = n - 1; i >= 0; i--) begin
            MOSI = tx[i];
            repeat (6) @(negedge CLK);
            rx = {rx[30:0], (sel == 0) ? MISO : MISO_b};
            SCK = 1'b1;
            repeat (6) @(negedge CLK);
            SCK = 1'b0;
        end
    endtask

    // One command window followed by one response window.
    task automatic applyStimulus(input vec_t v);
        int c0, d0, p0;
        logic [31:0] rx;
        c0 = cwe_cyc; d0 = dwe_cyc; p0 = pclk_cyc;
        spiStart(0);
        spiBits(0, {16'h0, v.frame}, 16, rx);
        repeat (10) @(negedge CLK);
        checkOutput("busy_after_cmd", {31'h0, busy}, 32'h1);
        spiEnd(0);
        checkOutput("busy_idle_o", {31'h0, busy}, 32'h0);
        checkOutput("cwe_cycles", cwe_cyc - c0, v.n_cwe);
        checkOutput("dwe_cycles", dwe_cyc - d0, v.n_dwe);
        checkOutput("pclk_cycles", pclk_cyc - p0, v.n_pclk);
        if (v.frame[14]) begin
            checkOutput("dadd", {24'h0, dadd_prg}, {24'h0, v.addr});
            if (!v.frame[15]) checkOutput("dout", {31'h0, dout_prg}, {31'h0, v.wdata[0]});
        end else begin
            checkOutput("cadd", {24'h0, cadd_prg}, {24'h0, v.addr});
            if (!v.frame[15]) checkOutput("cout", {28'h0, cout_prg}, {28'h0, v.wdata});
        end
        spiStart(0);
        spiBits(0, 32'h0, 16, rx);
        spiEnd(0);
        checkOutput("response", rx, {16'h0, v.resp});
    endtask

    initial begin
        logic [31:0] rx;
        int c0, d0, p0, e0;
        logic found;
        vec_t v;

        for (int i = 0; i < 256; i++) begin
            cmem[i] = 4'h0;
            dmem[i] = 1'b0;
        end
        for (int i = 0; i < 1024; i++) begin
            cmem_b[i] = 8'h00;
            dmem_b[i] = 8'h00;
        end

        //          frame     resp      cwe dwe pclk addr   wdata
        vecs[0] = '{16'h0A5C, 16'h0A5C, 3, 0, 1, 8'hA5, 4'hC};
        vecs[1] = '{16'h43F1, 16'h43F1, 0, 3, 1, 8'h3F, 4'h1};
        vecs[2] = '{16'hC3F0, 16'hC3F1, 0, 0, 1, 8'h3F, 4'h0};
        vecs[3] = '{16'h9A50, 16'h9A5C, 0, 0, 1, 8'hA5, 4'h0};
        vecs[4] = '{16'h4121, 16'h4121, 0, 3, 1, 8'h12, 4'h1};
        vecs[5] = '{16'hC120, 16'hC121, 0, 0, 1, 8'h12, 4'h0};
        vecs[6] = '{16'hC550, 16'hC550, 0, 0, 1, 8'h55, 4'h0};
        vecs[7] = '{16'h0337, 16'h0337, 3, 0, 1, 8'h33, 4'h7};
        vecs[8] = '{16'h8330, 16'h8337, 0, 0, 1, 8'h33, 4'h0};

        // Reset state of both instances.
        repeat (5) @(negedge CLK);
        checkOutput("reset_outputs",
                    {5'h0, MISO, cout_prg, cadd_prg, dout_prg, dadd_prg, cwe_prg, dwe_prg, prog_clk, busy, err},
                    32'h0);
        checkOutput("reset_outputs_b",
                    {busy_b, err_b, cwe_b, dwe_b, prog_clk_b, MISO_b, cadd_b, cout_b},
                    32'h0);
        RST_N = 1'b1;
        repeat (6) @(negedge CLK);

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i]);
        end

        // Burst write wrapping 0xFE -> 0xFF -> 0x00.
        wa_q.delete(); wd_q.delete();
        c0 = cwe_cyc; e0 = err_cyc;
        spiStart(0);
        spiBits(0, 32'h2FE1, 16, rx);
        spiBits(0, 32'h2, 4, rx);
        spiBits(0, 32'h3, 4, rx);
        spiEnd(0);
        checkOutput("burst_writes", wa_q.size(), 3);
        checkOutput("burst_cwe", cwe_cyc - c0, 9);
        checkOutput("burst_err", err_cyc - e0, 0);
        if (wa_q.size() == 3) begin
            checkOutput("burst_w0", {wa_q[0], wd_q[0]}, {20'h0, 8'hFE, 4'h1});
            checkOutput("burst_w1", {wa_q[1], wd_q[1]}, {20'h0, 8'hFF, 4'h2});
            checkOutput("burst_w2", {wa_q[2], wd_q[2]}, {20'h0, 8'h00, 4'h3});
        end
        spiStart(0);
        spiBits(0, 32'h0, 16, rx);
        spiEnd(0);
        checkOutput("burst_echo", rx, 32'h2003);

        // Burst with a partial second word: one write, err pulse, echo.
        wa_q.delete(); wd_q.delete();
        e0 = err_cyc;
        spiStart(0);
        spiBits(0, 32'h2101, 16, rx);
        spiBits(0, 32'h2, 2, rx);
        spiEnd(0);
        checkOutput("pburst_err", err_cyc - e0, 1);
        checkOutput("pburst_writes", wa_q.size(), 1);
        spiStart(0);
        spiBits(0, 32'h0, 16, rx);
        spiEnd(0);
        checkOutput("pburst_echo", rx, 32'h2101);

        // Command aborted after 9 bits.
        c0 = cwe_cyc; d0 = dwe_cyc; p0 = pclk_cyc; e0 = err_cyc;
        spiStart(0);
        spiBits(0, 32'h1A5, 9, rx);
        spiEnd(0);
        checkOutput("abort_err", err_cyc - e0, 1);
        checkOutput("abort_activity", (cwe_cyc - c0) + (dwe_cyc - d0) + (pclk_cyc - p0), 0);
        checkOutput("abort_busy", {31'h0, busy}, 32'h0);
        v = '{16'h8FE0, 16'h8FE1, 0, 0, 1, 8'hFE, 4'h0};
        applyStimulus(v);

        // Response window aborted after 5 bits returns to command mode.
        spiStart(0);
        spiBits(0, 32'h0BBD, 16, rx);
        spiEnd(0);
        e0 = err_cyc;
        spiStart(0);
        spiBits(0, 32'h0, 5, rx);
        spiEnd(0);
        checkOutput("rabort_bits", rx, 32'h01);
        checkOutput("rabort_err", err_cyc - e0, 1);
        applyStimulus(v);

        // Parametrised instance: FW = 22.
        spiStart(1);
        spiBits(1, 32'h03FFA7, 22, rx);
        spiEnd(1);
        checkOutput("b_cadd", {22'h0, cadd_b}, 32'h3FF);
        checkOutput("b_cout", {24'h0, cout_b}, 32'hA7);
        spiStart(1);
        spiBits(1, 32'h0, 22, rx);
        spiEnd(1);
        checkOutput("b_echo", rx, 32'h03FFA7);
        spiStart(1);
        spiBits(1, 32'h23FF00, 22, rx);
        spiEnd(1);
        spiStart(1);
        spiBits(1, 32'h0, 22, rx);
        spiEnd(1);
        checkOutput("b_read", rx, 32'h23FFA7);

        // Reset asserted while prog_clk is high (WR_CLK).
        spiStart(0);
        spiBits(0, 32'h0777 >> 1, 15, rx);
        MOSI = 1'b1;
        repeat (6) @(negedge CLK);
        SCK = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge CLK);
            if (prog_clk) found = 1'b1;
        end
        checkOutput("rst_wait_pclk", {31'h0, found}, 32'h1);
        checkOutput("rst_pre_cwe", {31'h0, cwe_prg}, 32'h1);
        RST_N = 1'b0;
        CS = 1'b1;
        SCK = 1'b0;
        MOSI = 1'b0;
        @(negedge CLK);
        checkOutput("rst_mid_outputs",
                    {5'h0, MISO, cout_prg, cadd_prg, dout_prg, dadd_prg, cwe_prg, dwe_prg, prog_clk, busy, err},
                    32'h0);
        repeat (2) @(negedge CLK);
        c0 = cwe_cyc; p0 = pclk_cyc;
        RST_N = 1'b1;
        repeat (10) @(negedge CLK);
        checkOutput("rst_no_enable", (cwe_cyc - c0) + (pclk_cyc - p0), 0);
        checkOutput("rst_busy", {31'h0, busy}, 32'h0);
        applyStimulus(vecs[3]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
